cache_nway: RTL and testbench

- Parametrised successor to the fixed 2-way, 8-set write-back L1 cache between the LC-3b datapath and physical memory.
- Generalises set count and associativity, using true-LRU age counters.
- Adds synchronous invalidate-on-reset and saturating hit/miss performance counters.
- CPU side is 16-bit word with byte mask; memory side is 128-bit line.

---
 rtl/cache_nway.sv | 190 +++++++++++++++++++
 tb/tb_cache_nway.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway.sv
// cache_nway: parametrised N-way set-associative write-back cache.
// It sits between a 16-bit CPU port (with byte mask) and a 128-bit line memory.
// Replacement is true LRU, tracked with one age counter per way per set.
// Hits and misses are counted in saturating counters.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   mem_address           CPU byte address (bit 0 ignored)
//   mem_read, mem_write   CPU request, held until mem_resp (both set = write)
//   mem_wdata             CPU write word
//   mem_byte_enable       [0] low byte, [1] high byte
//   mem_resp, mem_rdata   completion strobe and read word
//   pmem_read/pmem_write  line fill / writeback request to memory
//   pmem_address          line address, low nibble zero
//   pmem_wdata            victim line for writeback
//   pmem_rdata, pmem_resp fill line and memory completion
//   hit_count, miss_count saturating performance counters
//
// state     | meaning
// IDLE      | serve hits combinationally; detect misses and pick the victim
// WRITEBACK | dirty victim line is being written to memory
// FILL      | requested line is being fetched into the victim way
module cache_nway #(
  parameter int NUM_SETS = 8,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        mem_address,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [15:0]        mem_wdata,
  input  logic [1:0]         mem_byte_enable,
  output logic               mem_resp,
  output logic [15:0]        mem_rdata,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [15:0]        pmem_address,
  output logic [127:0]       pmem_wdata,
  input  logic [127:0]       pmem_rdata,
  input  logic               pmem_resp,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int AW = $clog2(WAYS);
  localparam int TW = 12 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

  state_e            state_q, state_d;
  logic [WAYS-1:0]   valid_q [NUM_SETS];
  logic [WAYS-1:0]   dirty_q [NUM_SETS];
  logic [TW-1:0]     tag_q   [NUM_SETS][WAYS];
  logic [127:0]      data_q  [NUM_SETS][WAYS];
  logic [AW-1:0]     age_q   [NUM_SETS][WAYS];
  logic [AW-1:0]     victim_q, victim_d;
  logic [CNT_W-1:0]  hit_q, miss_q;

  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [2:0]        wsel;
  logic              req;
  logic [WAYS-1:0]   match;
  logic              hit;
  logic [AW-1:0]     hit_way, lru_way, victim_sel;
  logic              any_invalid;
  logic [15:0]       old_word, new_word;
  logic              miss_event, fill_done;
  logic              unused_addr0;

  assign idx          = mem_address[3+IW:4];
  assign tag          = mem_address[15:4+IW];
  assign wsel         = mem_address[3:1];
  assign req          = mem_read | mem_write;
  assign unused_addr0 = mem_address[0];

  // Tag compare and victim choice: lowest invalid way wins, else the oldest way.
  always_comb begin
    match       = '0;
    hit_way     = '0;
    lru_way     = '0;
    victim_sel  = '0;
    any_invalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (match[w]) hit_way = AW'(w);
      if (age_q[idx][w] == AW'(WAYS - 1)) lru_way = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        victim_sel  = AW'(w);
        any_invalid = 1'b1;
      end
    end
    if (!any_invalid) victim_sel = lru_way;
  end

  assign hit      = $onehot(match);
  assign old_word = data_q[idx][hit_way][{wsel, 4'b0} +: 16];
  assign new_word = {mem_byte_enable[1] ? mem_wdata[15:8] : old_word[15:8],
                     mem_byte_enable[0] ? mem_wdata[7:0]  : old_word[7:0]};

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = old_word;
          end else begin
            victim_d = victim_sel;
            state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel]) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx][victim_q], idx, 4'b0};
        pmem_wdata   = data_q[idx][victim_q];
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, 4'b0};
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign miss_event = (state_q == IDLE) && req && !hit;
  assign fill_done  = (state_q == FILL) && pmem_resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (miss_event && (miss_q != '1)) miss_q <= miss_q + 1'b1;
      if (mem_resp) begin
        if (hit_q != '1) hit_q <= hit_q + 1'b1;
        if (mem_write) dirty_q[idx][hit_way] <= 1'b1;
        // Ways younger than the accessed one age by one; accessed way becomes newest.
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == hit_way) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][hit_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
      if (fill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (mem_resp && mem_write) data_q[idx][hit_way][{wsel, 4'b0} +: 16] <= new_word;
      if (fill_done) begin
        data_q[idx][victim_q] <= pmem_rdata;
        tag_q[idx][victim_q]  <= tag;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_nway.sv
module tb_cache_nway;
  localparam int NS = 8;
  localparam int W  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [15:0]  mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic         mem_resp, pmem_read, pmem_write;
  logic [15:0]  mem_rdata, pmem_address;
  logic [127:0] pmem_wdata;
  logic [15:0]  hit_count, miss_count;

  logic         c_mem_resp, c_pmem_read, c_pmem_write;
  logic [15:0]  c_mem_rdata, c_pmem_address;
  logic [127:0] c_pmem_wdata;
  logic [3:0]   c_hit_count, c_miss_count;

  always #5 clk = ~clk;

  cache_nway #(.NUM_SETS(NS), .WAYS(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count));

  // Same geometry with 4-bit counters: identical behaviour except saturation at 15.
  cache_nway #(.NUM_SETS(NS), .WAYS(W), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(c_mem_resp), .mem_rdata(c_mem_rdata), .pmem_read(c_pmem_read),
    .pmem_write(c_pmem_write), .pmem_address(c_pmem_address), .pmem_wdata(c_pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(c_hit_count), .miss_count(c_miss_count));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-set recency list (front = most recent), plain arrays for lines.
  bit           m_valid [NS][W];
  bit           m_dirty [NS][W];
  int           m_tag   [NS][W];
  logic [127:0] m_data  [NS][W];
  int           m_order [NS][$];
  logic [127:0] m_mem   [int];
  int           m_hits, m_misses;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    bit          exp_hit;
    bit          chk;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tbl[17];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mem_line(input int a);
    logic [127:0] l;
    if (m_mem.exists(a)) return m_mem[a];
    for (int k = 0; k < 8; k++) l[16*k +: 16] = 16'(a + 2*k) ^ 16'hBEEF;
    return l;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      m_order[s] = {};
      for (int w = 0; w < W; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_order[s].push_back(w);
      end
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_resp"},  mem_resp, 0);
    check({tag, "_mem_rdata"}, mem_rdata, 0);
    check({tag, "_pmem_read"}, pmem_read, 0);
    check({tag, "_pmem_write"}, pmem_write, 0);
    check({tag, "_pmem_addr"}, pmem_address, 0);
    check({tag, "_pmem_wdata"}, pmem_wdata, 0);
  endtask

  task automatic check_counters();
    check("hit_count",    hit_count,  m_hits);
    check("miss_count",   miss_count, m_misses);
    check("hit_count_c",  c_hit_count,  (m_hits > 15) ? 15 : m_hits);
    check("miss_count_c", c_miss_count, (m_misses > 15) ? 15 : m_misses);
  endtask

  // One CPU access, acting as the memory on a miss. Starts and ends just after a rising edge.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, input int lat, output bit dut_hit,
                        output logic [15:0] rword);
    int s, t, k, la, way, vic, wb, pos;
    logic [15:0] wv;
    s = int'(addr[6:4]);
    t = int'(addr[15:7]);
    k = int'(addr[3:1]);
    la = int'({addr[15:4], 4'b0});
    way = -1;
    for (int w = 0; w < W; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    mem_address = addr; mem_read = rd; mem_write = wr; mem_wdata = wd; mem_byte_enable = be;
    @(negedge clk);
    dut_hit = mem_resp;
    check("hit_detect", mem_resp, way >= 0);
    if (way < 0) begin
      vic = -1;
      for (int w = W - 1; w >= 0; w--) if (!m_valid[s][w]) vic = w;
      if (vic < 0) vic = m_order[s][W-1];
      m_misses++;
      tick();
      if (m_dirty[s][vic]) begin
        wb = (m_tag[s][vic] << 7) | (s << 4);
        for (int i = 0; i <= lat; i++) begin
          if (i == lat) pmem_resp = 1'b1;
          @(negedge clk);
          check("wb_pmem_write", pmem_write, 1);
          check("wb_pmem_read",  pmem_read, 0);
          check("wb_pmem_addr",  pmem_address, 16'(wb));
          check("wb_pmem_wdata", pmem_wdata, m_data[s][vic]);
          tick();
        end
        pmem_resp = 1'b0;
        m_mem[wb] = m_data[s][vic];
      end
      for (int i = 0; i <= lat; i++) begin
        if (i == lat) begin
          pmem_resp = 1'b1;
          pmem_rdata = mem_line(la);
        end else begin
          pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        check("fill_pmem_read",  pmem_read, 1);
        check("fill_pmem_write", pmem_write, 0);
        check("fill_pmem_addr",  pmem_address, 16'(la));
        check("fill_mem_resp",   mem_resp, 0);
        tick();
      end
      pmem_resp = 1'b0;
      m_valid[s][vic] = 1'b1;
      m_dirty[s][vic] = 1'b0;
      m_tag[s][vic]   = t;
      m_data[s][vic]  = mem_line(la);
      way = vic;
      @(negedge clk);
      check("post_fill_resp", mem_resp, 1);
    end
    rword = mem_rdata;
    check("resp_c", c_mem_resp, 1);
    check("resp_pmem_idle", {pmem_read, pmem_write}, 0);
    if (!wr) check("rdata", mem_rdata, m_data[s][way][16*k +: 16]);
    tick();
    if (wr) begin
      wv = m_data[s][way][16*k +: 16];
      if (be[0]) wv[7:0]  = wd[7:0];
      if (be[1]) wv[15:8] = wd[15:8];
      m_data[s][way][16*k +: 16] = wv;
      m_dirty[s][way] = 1'b1;
    end
    pos = 0;
    for (int i = 0; i < m_order[s].size(); i++) if (m_order[s][i] == way) pos = i;
    m_order[s].delete(pos);
    m_order[s].push_front(way);
    m_hits++;
    mem_read = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("gap_mem_resp", mem_resp, 0);
    check("gap_pmem", {pmem_read, pmem_write}, 0);
    check_counters();
    tick();
    pmem_resp = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1);
  end

  initial begin
    bit          h;
    logic [15:0] rw;
    int          tg, st;

    tbl[0]  = '{1, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 16'hBEEF};
    tbl[1]  = '{0, 1, 16'h0000, 16'h1234, 2'b01, 1, 0, 16'h0000};
    tbl[2]  = '{1, 0, 16'h0000, 16'h0000, 2'b00, 1, 1, 16'hBE34};
    tbl[3]  = '{1, 0, 16'h0082, 16'h0000, 2'b00, 0, 1, 16'hBE6D};
    tbl[4]  = '{1, 0, 16'h0104, 16'h0000, 2'b00, 0, 1, 16'hBFEB};
    tbl[5]  = '{1, 0, 16'h0186, 16'h0000, 2'b00, 0, 1, 16'hBF69};
    tbl[6]  = '{1, 0, 16'h0080, 16'h0000, 2'b00, 1, 1, 16'hBE6F};
    tbl[7]  = '{1, 0, 16'h0200, 16'h0000, 2'b00, 0, 1, 16'hBCEF};
    tbl[8]  = '{1, 0, 16'h0000, 16'h0000, 2'b00, 0, 1, 16'hBE34};
    tbl[9]  = '{1, 0, 16'h0186, 16'h0000, 2'b00, 1, 1, 16'hBF69};
    tbl[10] = '{1, 0, 16'h0102, 16'h0000, 2'b00, 0, 1, 16'hBFED};
    tbl[11] = '{0, 1, 16'h0010, 16'hA5A5, 2'b11, 0, 0, 16'h0000};
    tbl[12] = '{1, 0, 16'h0010, 16'h0000, 2'b00, 1, 1, 16'hA5A5};
    tbl[13] = '{1, 1, 16'h0012, 16'h7700, 2'b10, 1, 0, 16'h0000};
    tbl[14] = '{1, 0, 16'h0013, 16'h0000, 2'b00, 1, 1, 16'h77FD};
    tbl[15] = '{0, 1, 16'h0010, 16'hFFFF, 2'b00, 1, 0, 16'h0000};
    tbl[16] = '{1, 0, 16'h0010, 16'h0000, 2'b00, 1, 1, 16'hA5A5};

    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; mem_byte_enable = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    m_reset();
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check_counters();
    tick();

    for (int i = 0; i < 17; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, i % 3, h, rw);
      check($sformatf("tbl%0d_hit", i), h, tbl[i].exp_hit);
      if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), rw, tbl[i].exp_rd);
    end

    // Reset while a fill is outstanding (set 7 is empty, so this goes straight to FILL).
    mem_address = 16'h0370; mem_read = 1'b1;
    tick();
    @(negedge clk);
    check("rst_fill_active", pmem_read, 1);
    tick();
    reset = 1'b1; mem_read = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_fill");
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    m_reset();
    tick();
    // Dirty 0x77FD was discarded: refetch returns memory's copy.
    access(1, 0, 16'h0012, 16'h0, 2'b00, 1, h, rw);
    check("rst_refetch_hit", h, 0);
    check("rst_refetch_rdata", rw, 16'hBEFD);

    for (int i = 0; i < 20; i++) access(1, 0, 16'h0012, 16'h0, 2'b00, 0, h, rw);
    check("sat_hit_count_c", c_hit_count, 15);
    check("sat_hit_count", hit_count, 21);

    for (int i = 0; i < 250; i++) begin
      tg = $urandom_range(0, 5);
      st = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0, 1: access(1, 0, 16'((tg << 7) | (st << 4) | $urandom_range(0, 15)), 16'($urandom),
                     2'($urandom), $urandom_range(0, 3), h, rw);
        2:    access(0, 1, 16'((tg << 7) | (st << 4) | $urandom_range(0, 15)), 16'($urandom),
                     2'($urandom), $urandom_range(0, 3), h, rw);
        default: access(1, 1, 16'((tg << 7) | (st << 4) | $urandom_range(0, 15)), 16'($urandom),
                        2'($urandom), $urandom_range(0, 3), h, rw);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
